// File: rtl/prog_loader.sv
`default_nettype none
// ============================================================================
// Module   : prog_loader
// Purpose  : Streams 9-bit machine-code words into instruction memory from
//            address 0 and holds the CPU in reset until a program is loaded.
// Revision : 1.0 - initial release
// ============================================================================
module prog_loader #(
    parameter int D = 12
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         load_valid,
    input  logic [8:0]   load_data,
    input  logic         load_last,
    output logic         load_ready,
    output logic         wr_en,
    output logic [D-1:0] wr_addr,
    output logic [8:0]   wr_data,
    output logic [D:0]   word_count,
    output logic [8:0]   checksum,
    output logic         done,
    output logic         err,
    output logic         cpu_hold
);

    localparam logic [1:0] c_s_idle = 2'd0;
    localparam logic [1:0] c_s_load = 2'd1;
    localparam logic [1:0] c_s_done = 2'd2;
    localparam logic [1:0] c_s_err  = 2'd3;

    logic [1:0]   r_state;
    logic [1:0]   w_state_nxt;
    logic         w_accept;
    logic         w_new_session;
    logic [D-1:0] r_addr;
    logic         r_load_ready;
    logic         r_wr_en;
    logic [D-1:0] r_wr_addr;
    logic [8:0]   r_wr_data;
    logic [D:0]   r_word_count;
    logic [8:0]   r_checksum;
    logic         r_done;
    logic         r_err;
    logic         r_cpu_hold;

    always_comb begin
        w_state_nxt   = r_state;
        w_new_session = 1'b0;
        w_accept      = (r_state == c_s_load) && r_load_ready && load_valid;
        case (r_state)
            c_s_load: begin
                if (w_accept) begin
                    if (load_last) begin
                        w_state_nxt = c_s_done;
                    end else if (&r_addr) begin
                        w_state_nxt = c_s_err;
                    end
                end
            end
            default: begin
                if (start) begin
                    w_state_nxt   = c_s_load;
                    w_new_session = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= c_s_idle;
            r_addr       <= '0;
            r_load_ready <= 1'b0;
            r_wr_en      <= 1'b0;
            r_wr_addr    <= '0;
            r_wr_data    <= '0;
            r_word_count <= '0;
            r_checksum   <= '0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
            r_cpu_hold   <= 1'b1;
        end else begin
            r_state      <= w_state_nxt;
            // Status flags follow the next state so they appear the cycle after the deciding edge.
            r_load_ready <= (w_state_nxt == c_s_load);
            r_done       <= (w_state_nxt == c_s_done);
            r_err        <= (w_state_nxt == c_s_err);
            r_cpu_hold   <= (w_state_nxt != c_s_done);
            r_wr_en      <= w_accept;
            if (w_new_session) begin
                r_addr       <= '0;
                r_word_count <= '0;
                r_checksum   <= '0;
            end
            if (w_accept) begin
                r_wr_addr    <= r_addr;
                r_wr_data    <= load_data;
                r_word_count <= r_word_count + (D+1)'(1);
                r_checksum   <= r_checksum ^ load_data;
                if (!(&r_addr)) begin
                    r_addr <= r_addr + D'(1);
                end
            end
        end
    end

    assign load_ready = r_load_ready;
    assign wr_en      = r_wr_en;
    assign wr_addr    = r_wr_addr;
    assign wr_data    = r_wr_data;
    assign word_count = r_word_count;
    assign checksum   = r_checksum;
    assign done       = r_done;
    assign err        = r_err;
    assign cpu_hold   = r_cpu_hold;

endmodule
`default_nettype wire

// File: tb/tb_prog_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_prog_loader
// Purpose  : Scoreboard bench for prog_loader (D=4): expected writes are
//            queued at acceptance and popped by an independent write monitor.
// Revision : 1.0 - initial release
// ============================================================================
module tb_prog_loader;

    localparam int c_d = 4;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           start = 1'b0;
    logic           load_valid = 1'b0;
    logic [8:0]     load_data = '0;
    logic           load_last = 1'b0;
    logic           load_ready;
    logic           wr_en;
    logic [c_d-1:0] wr_addr;
    logic [8:0]     wr_data;
    logic [c_d:0]   word_count;
    logic [8:0]     checksum;
    logic           done;
    logic           err;
    logic           cpu_hold;

    prog_loader #(.D(c_d)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_last  (load_last),
        .load_ready (load_ready),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .word_count (word_count),
        .checksum   (checksum),
        .done       (done),
        .err        (err),
        .cpu_hold   (cpu_hold)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [c_d-1:0] addr;
        logic [8:0]     data;
        int             cyc;
    } wr_t;

    wr_t  exp_q[$];
    int   tests_run = 0;
    int   tests_failed = 0;
    int   cyc = 0;

    // Bench-side model of the session being loaded
    logic [c_d-1:0] mdl_addr;
    logic [8:0]     mdl_cs;
    int             mdl_cnt;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Write monitor: every wr_en pulse must match the oldest expected write.
    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("spurious_write_addr", {28'd0, wr_addr}, 32'hFFFF_FFFF);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                chk("write_addr", {28'd0, wr_addr}, {28'd0, e.addr});
                chk("write_data", {23'd0, wr_data}, {23'd0, e.data});
                chk("write_latency_cyc", cyc, e.cyc);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        mdl_addr = '0;
        mdl_cs   = '0;
        mdl_cnt  = 0;
    endtask

    // Present one word and wait up to max_cyc edges for acceptance.
    task automatic send_word(input logic [8:0] data, input logic last, input int max_cyc,
                             output bit accepted);
        bit rdy;
        wr_t e;
        accepted   = 1'b0;
        load_valid = 1'b1;
        load_data  = data;
        load_last  = last;
        for (int i = 0; i < max_cyc && !accepted; i++) begin
            rdy = load_ready;
            tick();
            if (rdy) begin
                accepted = 1'b1;
                e.addr = mdl_addr;
                e.data = data;
                e.cyc  = cyc;
                exp_q.push_back(e);
                mdl_addr = mdl_addr + 1'b1;
                mdl_cs   = mdl_cs ^ data;
                mdl_cnt++;
            end
        end
    endtask

    task automatic send_must(input logic [8:0] data, input logic last);
        bit acc;
        send_word(data, last, 10, acc);
        if (!acc) chk("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic idle_valid();
        load_valid = 1'b0;
        load_last  = 1'b0;
    endtask

    task automatic drain(input string name);
        tick();
        tick();
        chk(name, exp_q.size(), 32'd0);
    endtask

    task automatic chk_reset_values();
        chk("rst_load_ready", {31'd0, load_ready}, 32'd0);
        chk("rst_wr_en", {31'd0, wr_en}, 32'd0);
        chk("rst_wr_addr", {28'd0, wr_addr}, 32'd0);
        chk("rst_wr_data", {23'd0, wr_data}, 32'd0);
        chk("rst_word_count", {27'd0, word_count}, 32'd0);
        chk("rst_checksum", {23'd0, checksum}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_cpu_hold", {31'd0, cpu_hold}, 32'd1);
    endtask

    task automatic chk_done(input string tag, input int exp_cnt, input logic [8:0] exp_cs);
        chk({tag, "_done"}, {31'd0, done}, 32'd1);
        chk({tag, "_err"}, {31'd0, err}, 32'd0);
        chk({tag, "_cpu_hold"}, {31'd0, cpu_hold}, 32'd0);
        chk({tag, "_load_ready"}, {31'd0, load_ready}, 32'd0);
        chk({tag, "_word_count"}, {27'd0, word_count}, exp_cnt);
        chk({tag, "_checksum"}, {23'd0, checksum}, {23'd0, exp_cs});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit acc;
        logic [8:0] w;
        mdl_addr = '0;
        mdl_cs   = '0;
        mdl_cnt  = 0;

        // Reset state
        tick();
        tick();
        reset = 1'b0;
        chk_reset_values();
        tick();

        // Basic back-to-back load
        pulse_start();
        chk("load_ready_after_start", {31'd0, load_ready}, 32'd1);
        chk("cpu_hold_in_load", {31'd0, cpu_hold}, 32'd1);
        send_must(9'h07E, 1'b0);
        send_must(9'h066, 1'b0);
        send_must(9'h07A, 1'b1);
        idle_valid();
        chk_done("basic", 3, 9'h062);
        drain("basic_writes_drained");

        // Gapped valid, restarted from DONE
        pulse_start();
        send_must(9'h07E, 1'b0);
        idle_valid();
        tick();
        tick();
        send_must(9'h066, 1'b0);
        idle_valid();
        tick();
        tick();
        send_must(9'h07A, 1'b1);
        idle_valid();
        chk_done("gapped", 3, 9'h062);
        drain("gapped_writes_drained");

        // Exact fill of all 16 words
        pulse_start();
        for (int i = 0; i < 16; i++) begin
            w = 9'(i * 37 + 5);
            send_must(w, (i == 15));
        end
        idle_valid();
        chk_done("fill", 16, mdl_cs);
        drain("fill_writes_drained");

        // Overflow: 16 words without last, 17th must never be taken
        pulse_start();
        for (int i = 0; i < 16; i++) begin
            w = 9'(i * 11 + 300);
            send_must(w, 1'b0);
        end
        chk("ovf_err", {31'd0, err}, 32'd1);
        chk("ovf_done", {31'd0, done}, 32'd0);
        chk("ovf_cpu_hold", {31'd0, cpu_hold}, 32'd1);
        chk("ovf_load_ready", {31'd0, load_ready}, 32'd0);
        chk("ovf_word_count", {27'd0, word_count}, 32'd16);
        chk("ovf_checksum", {23'd0, checksum}, {23'd0, mdl_cs});
        send_word(9'h1FF, 1'b0, 5, acc);
        chk("ovf_17th_accepted", {31'd0, acc}, 32'd0);
        idle_valid();
        chk("ovf_word_count_frozen", {27'd0, word_count}, 32'd16);
        drain("ovf_writes_drained");

        // Reset asserted on the edge of the 2nd accept
        pulse_start();
        send_must(9'h0A1, 1'b0);
        load_valid = 1'b1;
        load_data  = 9'h0B2;
        load_last  = 1'b0;
        reset      = 1'b1;
        tick();
        reset = 1'b0;
        idle_valid();
        chk_reset_values();
        drain("rst_writes_drained");
        pulse_start();
        send_must(9'h1A5, 1'b1);
        idle_valid();
        chk_done("post_rst", 1, 9'h1A5);
        drain("post_rst_writes_drained");

        // Reload from DONE
        pulse_start();
        chk("reload_cpu_hold", {31'd0, cpu_hold}, 32'd1);
        chk("reload_done", {31'd0, done}, 32'd0);
        chk("reload_word_count", {27'd0, word_count}, 32'd0);
        chk("reload_checksum", {23'd0, checksum}, 32'd0);
        send_must(9'h155, 1'b1);
        idle_valid();
        chk_done("reload", 1, 9'h155);
        drain("reload_writes_drained");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire
